// File: rtl/perceptron_seq.sv
// rtl/perceptron_seq.sv - single-neuron perceptron sequencer
// One shared signed multiplier, step activation, optional learning-rule update.
module perceptron_seq #(
    parameter int N_INPUTS = 4,
    parameter int DATA_W   = 8,
    parameter int WEIGHT_W = 8,
    parameter int ACC_W    = 20,
    parameter int LR_SHIFT = 0
) (
    input  logic                         clk_i,
    input  logic                         reset_ni,
    input  logic                         start_i,
    input  logic                         train_i,
    input  logic [N_INPUTS*DATA_W-1:0]   x_i,
    input  logic                         target_i,
    input  logic                         wr_en_i,
    input  logic [$clog2(N_INPUTS+1)-1:0] wr_idx_i,
    input  logic [WEIGHT_W-1:0]          wr_data_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         y_o,
    output logic [ACC_W-1:0]             acc_o,
    output logic                         err_o,
    output logic [N_INPUTS*WEIGHT_W-1:0] weights_o,
    output logic [WEIGHT_W-1:0]          bias_o
);
    localparam int IDX_W  = $clog2(N_INPUTS+1);
    localparam int PROD_W = DATA_W + WEIGHT_W;
    localparam int DX_W   = DATA_W + 1;
    localparam int SUM_W  = ((WEIGHT_W > DATA_W) ? WEIGHT_W : DATA_W) + 2;
    localparam logic signed [WEIGHT_W-1:0] W_MAX = {1'b0, {(WEIGHT_W-1){1'b1}}};
    localparam logic signed [WEIGHT_W-1:0] W_MIN = {1'b1, {(WEIGHT_W-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_MAC, S_ACT, S_UPD, S_DONE} state_t;

    state_t                      state_q, state_d;
    logic [IDX_W-1:0]            k_q, k_d;
    logic signed [ACC_W-1:0]     acc_q, acc_d;
    logic signed [ACC_W-1:0]     res_q, res_d;
    logic                        y_q, y_d;
    logic                        err_q, err_d;
    logic                        target_q, target_d;
    logic                        train_q, train_d;
    logic signed [DATA_W-1:0]    x_q [N_INPUTS];
    logic signed [DATA_W-1:0]    x_d [N_INPUTS];
    logic signed [WEIGHT_W-1:0]  w_q [N_INPUTS];
    logic signed [WEIGHT_W-1:0]  w_d [N_INPUTS];
    logic signed [WEIGHT_W-1:0]  bias_q, bias_d;

    logic signed [DATA_W-1:0]    x_sel;
    logic signed [WEIGHT_W-1:0]  w_sel;
    logic signed [PROD_W-1:0]    prod;
    logic signed [ACC_W-1:0]     sum_act;
    logic                        y_act;
    logic signed [DX_W-1:0]      dsel, delta;
    logic signed [SUM_W-1:0]     upd_sum, bias_sum;

    function automatic logic signed [WEIGHT_W-1:0] sat_w(input logic signed [SUM_W-1:0] v);
        if (v > SUM_W'(W_MAX)) return W_MAX;
        if (v < SUM_W'(W_MIN)) return W_MIN;
        return v[WEIGHT_W-1:0];
    endfunction

    // Datapath shared by MAC and UPD: operand pair selected by k_q.
    always_comb begin
        x_sel = '0;
        w_sel = '0;
        for (int i = 0; i < N_INPUTS; i++) begin
            if (k_q == IDX_W'(i)) begin
                x_sel = x_q[i];
                w_sel = w_q[i];
            end
        end
        prod     = PROD_W'(x_sel) * PROD_W'(w_sel);
        sum_act  = acc_q + ACC_W'(bias_q);
        y_act    = ~sum_act[ACC_W-1];
        dsel     = target_q ? DX_W'(x_sel) : -DX_W'(x_sel);
        delta    = dsel >>> LR_SHIFT;
        upd_sum  = SUM_W'(w_sel) + SUM_W'(delta);
        bias_sum = SUM_W'(bias_q) + (target_q ? SUM_W'(1) : SUM_W'(-1));
    end

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        acc_d    = acc_q;
        res_d    = res_q;
        y_d      = y_q;
        err_d    = err_q;
        target_d = target_q;
        train_d  = train_q;
        x_d      = x_q;
        w_d      = w_q;
        bias_d   = bias_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    for (int i = 0; i < N_INPUTS; i++) x_d[i] = x_i[i*DATA_W +: DATA_W];
                    target_d = target_i;
                    train_d  = train_i;
                    acc_d    = '0;
                    k_d      = '0;
                    state_d  = S_MAC;
                end else if (wr_en_i) begin
                    for (int i = 0; i < N_INPUTS; i++) begin
                        if (wr_idx_i == IDX_W'(i)) w_d[i] = wr_data_i;
                    end
                    if (wr_idx_i == IDX_W'(N_INPUTS)) bias_d = wr_data_i;
                end
            end
            S_MAC: begin
                acc_d = acc_q + ACC_W'(prod);
                k_d   = k_q + IDX_W'(1);
                if (k_q == IDX_W'(N_INPUTS-1)) state_d = S_ACT;
            end
            S_ACT: begin
                res_d   = sum_act;
                y_d     = y_act;
                err_d   = (y_act != target_q);
                k_d     = '0;
                state_d = (train_q && (y_act != target_q)) ? S_UPD : S_DONE;
            end
            S_UPD: begin
                k_d = k_q + IDX_W'(1);
                // Weights first, bias on the extra final cycle.
                if (k_q == IDX_W'(N_INPUTS)) begin
                    bias_d  = sat_w(bias_sum);
                    state_d = S_DONE;
                end else begin
                    for (int i = 0; i < N_INPUTS; i++) begin
                        if (k_q == IDX_W'(i)) w_d[i] = sat_w(upd_sum);
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q  <= S_IDLE;
            k_q      <= '0;
            acc_q    <= '0;
            res_q    <= '0;
            y_q      <= 1'b0;
            err_q    <= 1'b0;
            target_q <= 1'b0;
            train_q  <= 1'b0;
            bias_q   <= '0;
            for (int i = 0; i < N_INPUTS; i++) begin
                x_q[i] <= '0;
                w_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            acc_q    <= acc_d;
            res_q    <= res_d;
            y_q      <= y_d;
            err_q    <= err_d;
            target_q <= target_d;
            train_q  <= train_d;
            bias_q   <= bias_d;
            x_q      <= x_d;
            w_q      <= w_d;
        end
    end

    always_comb begin
        weights_o = '0;
        for (int i = 0; i < N_INPUTS; i++) weights_o[i*WEIGHT_W +: WEIGHT_W] = w_q[i];
    end

    assign busy_o = (state_q != S_IDLE);
    assign done_o = (state_q == S_DONE);
    assign y_o    = y_q;
    assign acc_o  = res_q;
    assign err_o  = err_q;
    assign bias_o = bias_q;

endmodule
